tcm_stream_writer: RTL and testbench
====================================

// Module: tcm_stream_writer
// PURPOSE
// - Upstream feeder for port 2 of the dual-port TCM (512 x 32, byte-enabled; writes land in one cycle, no waitrequest).
// - Accepts a byte stream (keypad/UART entry path) and packs bytes little-endian into 32-bit words.
// - Writes the packed words into a fixed TCM message window, then flags the Nios II with the message length.
// - CPU reads the message over port 1 and releases the block with msg_ack.
// PARAMETERS
// - BASE_WORD    256  first TCM word address of the message window
// - DEPTH_WORDS  64   window size in words; BASE_WORD+DEPTH_WORDS <= 512
// - ADDR_W       9    TCM word-address width
// PORTS
// - clk             in   1       system clock (same clock as TCM clk2)
// - reset_n         in   1       asynchronous active-low reset
// - in_valid        in   1       stream byte valid
// - in_ready        out  1       stream byte accepted when in_valid & in_ready
// - in_data         in   8       stream byte
// - in_eop          in   1       qualifies the last byte of a message
// - tcm_address     out  ADDR_W  to TCM address2
// - tcm_byteenable  out  4       to TCM byteenable2
// - tcm_chipselect  out  1       to TCM chipselect2
// - tcm_write       out  1       to TCM write2
// - tcm_writedata   out  32      to TCM writedata2
// - tcm_clken       out  1       to TCM clken2; constant 1
// - msg_done        out  1       level: a message is complete and stored
// - msg_len         out  12      bytes received in the message (including dropped bytes, saturates at 4095)
// - msg_overflow    out  1       the message exceeded DEPTH_WORDS*4 bytes
// - msg_sum         out  16      running byte sum (see CONFIGURATION)
// - msg_ack         in   1       one-cycle CPU release pulse
// BEHAVIOUR
// - Reset: state=PACK; in_ready=1; tcm_chipselect/write=0; byteenable=0; address=BASE_WORD; writedata=0; msg_*=0.
// - States: PACK, WRITE, DONE.
// - PACK (in_ready=1): an accepted byte goes to lane k (k = byte count mod 4, bits 8k+7:8k) and sets byteenable[k].
// -   If lane 3 is filled or in_eop is set, go to WRITE on the next cycle. Otherwise stay in PACK.
// - WRITE (in_ready=0): chipselect=write=1 for exactly one cycle, with the address, data and byteenable accumulated so far.
// -   Next cycle: address increments, lanes and byteenable clear.
// -   Then go to DONE if eop was captured, otherwise back to PACK.
// - Latency: the 4th byte accepted at cycle N is written at N+1; the next byte can be accepted at N+2.
// - Partial final word: only the filled lanes are enabled. Example: 5 bytes give writes of be=4'hF then be=4'h1.
// - Overflow: once DEPTH_WORDS words are written, further bytes are still accepted (no stall) but dropped.
// -   Dropped bytes cause no WRITE and set msg_overflow.
// -   msg_len still counts them; an eop on a dropped byte goes directly to DONE.
// -   The address never leaves the window.
// - DONE (in_ready=0): msg_done=1; msg_len, msg_overflow and msg_sum are held.
// -   msg_ack returns to PACK. Address goes to BASE_WORD; counters, flags and sum clear on the same edge.
// - msg_ack outside DONE is ignored. in_valid during WRITE/DONE is not accepted.
// - Reset mid-message: abandons the message. No further TCM write; any partially written words are left as they are.
// CONFIGURATION
// - Macro TSW_BYTE_SUM_EN: if defined, msg_sum = mod-2^16 sum of all accepted bytes, including dropped bytes.
// -   If not defined, msg_sum is tied to 16'h0000 and no adder is built.
// TESTING
// - Send bytes 31,32,33,34 with eop on 34 -> one write: addr 256, data 32'h34333231, be F.
//   Then msg_done=1, msg_len=4.
// - Send 5 bytes 01..05, eop on 05 -> writes: addr 256 data 04030201 be F; addr 257 data 00000005 be 1.
//   Then msg_len=5, and in_ready is low in each WRITE cycle.
// - Send 260 bytes with DEPTH_WORDS=64 -> exactly 64 writes (addr 256..319).
//   Then msg_overflow=1, msg_len=260, and in_ready never drops outside WRITE/DONE.
// - In DONE, hold in_valid high and then pulse msg_ack -> no byte is accepted in DONE.
//   Next message starts at addr 256 with msg_len=1 after one byte.
// - Assert reset_n low after 2 of 4 bytes -> no write occurs; outputs take reset values.
//   A following 4-byte message writes addr 256.
// - TSW_BYTE_SUM_EN defined, bytes FF,FF,02 -> msg_sum=16'h0200. Macro undefined -> msg_sum=0.

Source files
------------

// File: rtl/tcm_stream_writer_if.sv
// Byte-stream handshake into tcm_stream_writer.
// master = byte source, slave = the writer consuming bytes.
interface tcm_stream_writer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_eop;

    modport master (output in_valid, output in_data, output in_eop, input in_ready);
    modport slave  (input in_valid, input in_data, input in_eop, output in_ready);
endinterface

// File: rtl/tcm_stream_writer.sv
// Packs a byte stream little-endian into 32-bit words, writes them to a TCM window and flags the CPU.
// Optional feature macro: TSW_BYTE_SUM_EN enables the mod-2^16 running byte sum on msg_sum.
module tcm_stream_writer #(
    parameter int BASE_WORD   = 256,
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 9
) (
    input  logic                 clk,
    input  logic                 reset_n,
    tcm_stream_writer_if.slave   stream,
    output logic [ADDR_W-1:0]    tcm_address,
    output logic [3:0]           tcm_byteenable,
    output logic                 tcm_chipselect,
    output logic                 tcm_write,
    output logic [31:0]          tcm_writedata,
    output logic                 tcm_clken,
    output logic                 msg_done,
    output logic [11:0]          msg_len,
    output logic                 msg_overflow,
    output logic [15:0]          msg_sum,
    input  logic                 msg_ack
);

    localparam int                CNT_W     = $clog2(DEPTH_WORDS + 1);
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_WORD);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH_WORDS);
    localparam logic [11:0]       LEN_MAX   = 12'hFFF;

    typedef enum logic [1:0] {
        S_PACK  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       data_r;
    logic [3:0]        be_r;
    logic              wr_r;
    logic              ready_r;
    logic              done_r;
    logic              eop_r;
    logic [CNT_W-1:0]  word_cnt_r;
    logic [11:0]       len_r;
    logic              ovf_r;

    logic              accept_s;
    logic              full_s;
    logic              last_word_s;
    logic [11:0]       len_inc_s;

    assign accept_s    = stream.in_valid & ready_r;
    assign full_s      = (word_cnt_r == DEPTH_CNT);
    // The final window word keeps the address in place so it never leaves the window.
    assign last_word_s = (word_cnt_r == (DEPTH_CNT - CNT_W'(1)));
    assign len_inc_s   = (len_r == LEN_MAX) ? len_r : (len_r + 12'd1);

`ifdef TSW_BYTE_SUM_EN
    logic [15:0] sum_r;

    // Running byte sum over every accepted byte, dropped bytes included.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_r <= 16'h0000;
        end else if ((state_r == S_PACK) && accept_s) begin
            sum_r <= sum_r + {8'h00, stream.in_data};
        end else if ((state_r == S_DONE) && msg_ack) begin
            sum_r <= 16'h0000;
        end
    end

    assign msg_sum = sum_r;
`else
    assign msg_sum = 16'h0000;
`endif

    // Message FSM: byte packing, single-cycle TCM write, completion hand-off.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= S_PACK;
            addr_r     <= BASE_ADDR;
            data_r     <= 32'h0000_0000;
            be_r       <= 4'h0;
            wr_r       <= 1'b0;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
            eop_r      <= 1'b0;
            word_cnt_r <= '0;
            len_r      <= 12'h000;
            ovf_r      <= 1'b0;
        end else begin
            case (state_r)
                S_PACK: begin
                    if (accept_s) begin
                        len_r <= len_inc_s;
                        if (full_s) begin
                            ovf_r <= 1'b1;
                            if (stream.in_eop) begin
                                state_r <= S_DONE;
                                ready_r <= 1'b0;
                                done_r  <= 1'b1;
                            end
                        end else begin
                            data_r[{len_r[1:0], 3'b000} +: 8] <= stream.in_data;
                            be_r[len_r[1:0]]                  <= 1'b1;
                            eop_r                             <= stream.in_eop;
                            if ((len_r[1:0] == 2'd3) || stream.in_eop) begin
                                state_r <= S_WRITE;
                                ready_r <= 1'b0;
                                wr_r    <= 1'b1;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    wr_r       <= 1'b0;
                    data_r     <= 32'h0000_0000;
                    be_r       <= 4'h0;
                    word_cnt_r <= word_cnt_r + CNT_W'(1);
                    if (!last_word_s) begin
                        addr_r <= addr_r + ADDR_W'(1);
                    end
                    if (eop_r) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= S_PACK;
                        ready_r <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (msg_ack) begin
                        state_r    <= S_PACK;
                        ready_r    <= 1'b1;
                        done_r     <= 1'b0;
                        eop_r      <= 1'b0;
                        addr_r     <= BASE_ADDR;
                        word_cnt_r <= '0;
                        len_r      <= 12'h000;
                        ovf_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r <= S_PACK;
                    ready_r <= 1'b1;
                    wr_r    <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign stream.in_ready = ready_r;
    assign tcm_address     = addr_r;
    assign tcm_byteenable  = be_r;
    assign tcm_chipselect  = wr_r;
    assign tcm_write       = wr_r;
    assign tcm_writedata   = data_r;
    assign tcm_clken       = 1'b1;
    assign msg_done        = done_r;
    assign msg_len         = len_r;
    assign msg_overflow    = ovf_r;

endmodule

// File: tb/tb_tcm_stream_writer.sv
// Scoreboard bench for tcm_stream_writer: a message-level model queues expected TCM writes
// and completion results; an independent monitor pops and compares as the DUT presents them.
module tb_tcm_stream_writer;

    localparam int BASE  = 256;
    localparam int DEPTH = 64;
    localparam int AW    = 9;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] tcm_address;
    logic [3:0]    tcm_byteenable;
    logic          tcm_chipselect;
    logic          tcm_write;
    logic [31:0]   tcm_writedata;
    logic          tcm_clken;
    logic          msg_done;
    logic [11:0]   msg_len;
    logic          msg_overflow;
    logic [15:0]   msg_sum;
    logic          msg_ack = 1'b0;

    tcm_stream_writer_if sif ();

    always #5 clk = ~clk;

    tcm_stream_writer #(.BASE_WORD(BASE), .DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stream         (sif),
        .tcm_address    (tcm_address),
        .tcm_byteenable (tcm_byteenable),
        .tcm_chipselect (tcm_chipselect),
        .tcm_write      (tcm_write),
        .tcm_writedata  (tcm_writedata),
        .tcm_clken      (tcm_clken),
        .msg_done       (msg_done),
        .msg_len        (msg_len),
        .msg_overflow   (msg_overflow),
        .msg_sum        (msg_sum),
        .msg_ack        (msg_ack)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    be;
    } wr_t;

    typedef struct packed {
        logic [11:0] len;
        logic        ovf;
        logic [15:0] sum;
    } msg_t;

    wr_t        exp_wr[$];
    msg_t       exp_msg[$];
    logic [7:0] msg_bytes[$];
    int         checks = 0;
    int         fails  = 0;
    logic       done_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Message-level reference: word w holds bytes 4w..4w+3, only DEPTH words are stored.
    task automatic model_msg();
        int   n;
        int   sum;
        wr_t  e;
        msg_t m;
        n   = msg_bytes.size();
        sum = 0;
        for (int w = 0; w < (n + 3) / 4 && w < DEPTH; w++) begin
            e.addr = AW'(BASE + w);
            e.data = 32'h0000_0000;
            e.be   = 4'h0;
            for (int b = 0; b < 4; b++) begin
                if (4 * w + b < n) begin
                    e.data[8*b +: 8] = msg_bytes[4 * w + b];
                    e.be[b]          = 1'b1;
                end
            end
            exp_wr.push_back(e);
        end
        for (int i = 0; i < n; i++) sum += int'(msg_bytes[i]);
        m.len = (n > 4095) ? 12'hFFF : 12'(n);
        m.ovf = (n > DEPTH * 4);
`ifdef TSW_BYTE_SUM_EN
        m.sum = sum[15:0];
`else
        m.sum = 16'h0000;
`endif
        exp_msg.push_back(m);
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken, in_valid still high.
    task automatic send_byte(input logic [7:0] d, input logic eop);
        bit ok;
        ok = 1'b0;
        sif.in_valid = 1'b1;
        sif.in_data  = d;
        sif.in_eop   = eop;
        for (int i = 0; i < 200; i++) begin
            if (sif.in_ready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        check("accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic send_msg(input bit gaps);
        int n;
        model_msg();
        n = msg_bytes.size();
        for (int i = 0; i < n; i++) begin
            send_byte(msg_bytes[i], (i == n - 1));
            if (gaps && (i < n - 1) && ($urandom_range(0, 2) == 0)) begin
                sif.in_valid = 1'b0;
                if ($urandom_range(0, 1) == 1) msg_ack = 1'b1;
                @(negedge clk);
                msg_ack = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        sif.in_valid = 1'b0;
        sif.in_eop   = 1'b0;
    endtask

    // Waits for DONE, holds in_valid high through DONE, then releases with a one-cycle ack.
    task automatic finish_msg(input int hold);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (msg_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done_timeout", 64'(seen), 64'd1);
        sif.in_valid = 1'b1;
        sif.in_data  = 8'(($urandom));
        sif.in_eop   = 1'b0;
        repeat (hold) @(negedge clk);
        check("ready_in_done", 64'(sif.in_ready), 64'd0);
        msg_ack = 1'b1;
        @(negedge clk);
        msg_ack      = 1'b0;
        sif.in_valid = 1'b0;
        check("ack_done_clear", 64'(msg_done), 64'd0);
        check("ack_addr", 64'(tcm_address), 64'(BASE));
        check("ack_len", 64'(msg_len), 64'd0);
        check("ack_ovf", 64'(msg_overflow), 64'd0);
        check("ack_sum", 64'(msg_sum), 64'd0);
        check("ack_ready", 64'(sif.in_ready), 64'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", 64'(sif.in_ready), 64'd1);
        check("rst_cs", 64'(tcm_chipselect), 64'd0);
        check("rst_write", 64'(tcm_write), 64'd0);
        check("rst_be", 64'(tcm_byteenable), 64'd0);
        check("rst_addr", 64'(tcm_address), 64'(BASE));
        check("rst_data", 64'(tcm_writedata), 64'd0);
        check("rst_done", 64'(msg_done), 64'd0);
        check("rst_len", 64'(msg_len), 64'd0);
        check("rst_ovf", 64'(msg_overflow), 64'd0);
        check("rst_sum", 64'(msg_sum), 64'd0);
    endtask

    // Monitor: pops expected writes and message results whenever the DUT presents them.
    always @(negedge clk) begin
        if (reset_n) begin
            if (tcm_chipselect || tcm_write) begin
                check("cs_eq_write", 64'(tcm_chipselect & tcm_write), 64'd1);
                check("ready_in_write", 64'(sif.in_ready), 64'd0);
                check("clken", 64'(tcm_clken), 64'd1);
                if (exp_wr.size() == 0) begin
                    check("unexpected_write_addr", 64'(tcm_address), 64'h1FFFF);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", 64'(tcm_address), 64'(e.addr));
                    check("wr_data", 64'(tcm_writedata), 64'(e.data));
                    check("wr_be", 64'(tcm_byteenable), 64'(e.be));
                end
            end else if (!msg_done) begin
                check("ready_outside_write_done", 64'(sif.in_ready), 64'd1);
            end
            if (msg_done && !done_prev) begin
                check("writes_drained", 64'(exp_wr.size()), 64'd0);
                if (exp_msg.size() == 0) begin
                    check("unexpected_done_len", 64'(msg_len), 64'hFFFFF);
                end else begin
                    msg_t m;
                    m = exp_msg.pop_front();
                    check("msg_len", 64'(msg_len), 64'(m.len));
                    check("msg_overflow", 64'(msg_overflow), 64'(m.ovf));
                    check("msg_sum", 64'(msg_sum), 64'(m.sum));
                end
            end
            done_prev <= msg_done;
        end else begin
            done_prev <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sif.in_valid = 1'b0;
        sif.in_data  = 8'h00;
        sif.in_eop   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset_n = 1'b1;
        @(negedge clk);

        msg_bytes = '{8'h31, 8'h32, 8'h33, 8'h34};
        send_msg(1'b0);
        finish_msg(2);

        msg_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_msg(1'b1);
        finish_msg(1);

        msg_bytes = '{8'hFF, 8'hFF, 8'h02};
        send_msg(1'b0);
        finish_msg(1);

        // Abandon a message after two bytes; nothing may be written.
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        sif.in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        msg_bytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        send_msg(1'b0);
        finish_msg(1);

        foreach (msg_bytes[i]) msg_bytes[i] = 8'h00;
        msg_bytes.delete();
        for (int i = 0; i < 260; i++) msg_bytes.push_back(8'($urandom));
        send_msg(1'b0);
        finish_msg(3);

        // Single-byte message right after a release.
        msg_bytes = '{8'h5A};
        model_msg();
        send_byte(8'h5A, 1'b1);
        sif.in_valid = 1'b0;
        check("len_after_one_byte", 64'(msg_len), 64'd1);
        finish_msg(1);

        // Window boundaries: exactly full, and one byte past full.
        for (int k = 256; k <= 257; k++) begin
            msg_bytes.delete();
            for (int i = 0; i < k; i++) msg_bytes.push_back(8'($urandom));
            send_msg(1'b1);
            finish_msg(1);
        end

        for (int t = 0; t < 30; t++) begin
            int n;
            n = $urandom_range(1, 40);
            msg_bytes.delete();
            for (int i = 0; i < n; i++) msg_bytes.push_back(8'($urandom));
            send_msg(1'b1);
            finish_msg($urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        check("final_wr_queue_empty", 64'(exp_wr.size()), 64'd0);
        check("final_msg_queue_empty", 64'(exp_msg.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
